// File: rtl/parking_billing_ctrl.sv
// Parking session controller: keeps a time base and an occupancy map, stamps entry
// times into the per-car record memory, and writes back a saturated fee on exit.
module parking_billing_ctrl #(
  parameter int TICK_DIV = 100,
  parameter int RATE     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [2:0] req_car,
  output logic       req_ready,
  output logic       done,
  output logic       err,
  output logic [9:0] fee,
  output logic [7:0] occupied,
  output logic [9:0] now_time,
  output logic [2:0] mem_car_sel,
  output logic       mem_write_entry,
  output logic       mem_write_cost,
  output logic [9:0] mem_entry_time_in,
  output logic [9:0] mem_cost_in,
  input  logic [9:0] mem_entry_time_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY_WR,
    EXIT_RD,
    EXIT_CALC,
    EXIT_WR,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    now_q, now_d;
  logic [7:0]    occ_q, occ_d;
  logic [9:0]    fee_q, fee_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [2:0]    sel_q, sel_d;
  logic          wr_entry_q, wr_entry_d;
  logic          wr_cost_q, wr_cost_d;
  logic [9:0]    et_in_q, et_in_d;
  logic [9:0]    cost_in_q, cost_in_d;
  logic [2:0]    car_q, car_d;
  logic [9:0]    t_req_q, t_req_d;

  logic [9:0]    dur;
  logic [31:0]   product;
  logic [9:0]    cost_sat;

  // Modulo-1024 subtraction gives the right duration across a time-base wrap.
  always_comb begin
    dur      = t_req_q - mem_entry_time_out;
    product  = 32'(dur) * 32'(RATE);
    cost_sat = (product > 32'd1023) ? 10'd1023 : product[9:0];
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    now_d      = now_q;
    occ_d      = occ_q;
    fee_d      = fee_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sel_d      = sel_q;
    wr_entry_d = 1'b0;
    wr_cost_d  = 1'b0;
    et_in_d    = et_in_q;
    cost_in_d  = cost_in_q;
    car_d      = car_q;
    t_req_d    = t_req_q;

    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      now_d   = now_q + 10'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // Outputs are registered, so each state sets up the strobes of the state it enters.
    case (state_q)
      IDLE: begin
        if (entry_req && exit_req) begin
          err_d = 1'b1;
        end else if (entry_req) begin
          if (occ_q[req_car]) begin
            err_d = 1'b1;
          end else begin
            car_d      = req_car;
            t_req_d    = now_q;
            sel_d      = req_car;
            et_in_d    = now_q;
            wr_entry_d = 1'b1;
            state_d    = ENTRY_WR;
          end
        end else if (exit_req) begin
          if (!occ_q[req_car]) begin
            err_d = 1'b1;
          end else begin
            car_d   = req_car;
            t_req_d = now_q;
            sel_d   = req_car;
            state_d = EXIT_RD;
          end
        end
      end
      ENTRY_WR: begin
        occ_d[car_q] = 1'b1;
        done_d       = 1'b1;
        state_d      = FINISH;
      end
      EXIT_RD: begin
        state_d = EXIT_CALC;
      end
      EXIT_CALC: begin
        cost_in_d = cost_sat;
        wr_cost_d = 1'b1;
        state_d   = EXIT_WR;
      end
      EXIT_WR: begin
        fee_d        = cost_in_q;
        occ_d[car_q] = 1'b0;
        done_d       = 1'b1;
        state_d      = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      now_q      <= '0;
      occ_q      <= '0;
      fee_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sel_q      <= '0;
      wr_entry_q <= 1'b0;
      wr_cost_q  <= 1'b0;
      et_in_q    <= '0;
      cost_in_q  <= '0;
      car_q      <= '0;
      t_req_q    <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      now_q      <= now_d;
      occ_q      <= occ_d;
      fee_q      <= fee_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
      wr_entry_q <= wr_entry_d;
      wr_cost_q  <= wr_cost_d;
      et_in_q    <= et_in_d;
      cost_in_q  <= cost_in_d;
      car_q      <= car_d;
      t_req_q    <= t_req_d;
    end
  end

  assign req_ready         = (state_q == IDLE);
  assign done              = done_q;
  assign err               = err_q;
  assign fee               = fee_q;
  assign occupied          = occ_q;
  assign now_time          = now_q;
  assign mem_car_sel       = sel_q;
  assign mem_write_entry   = wr_entry_q;
  assign mem_write_cost    = wr_cost_q;
  assign mem_entry_time_in = et_in_q;
  assign mem_cost_in       = cost_in_q;

endmodule

// File: tb/tb_parking_billing_ctrl.sv
// Directed bench for parking_billing_ctrl with TICK_DIV=4, RATE=2 and a behavioural record memory.
module tb_parking_billing_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] req_car = '0;
  logic       req_ready, done, err;
  logic [9:0] fee, now_time, mem_entry_time_in, mem_cost_in, mem_entry_time_out;
  logic [7:0] occupied;
  logic [2:0] mem_car_sel;
  logic       mem_write_entry, mem_write_cost;

  logic [9:0] mem_et [8];
  logic [9:0] mem_cost [8];

  int checks = 0;
  int fails  = 0;

  parking_billing_ctrl #(.TICK_DIV(4), .RATE(2)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req), .req_car(req_car),
    .req_ready(req_ready), .done(done), .err(err), .fee(fee), .occupied(occupied),
    .now_time(now_time), .mem_car_sel(mem_car_sel), .mem_write_entry(mem_write_entry),
    .mem_write_cost(mem_write_cost), .mem_entry_time_in(mem_entry_time_in),
    .mem_cost_in(mem_cost_in), .mem_entry_time_out(mem_entry_time_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_entry) mem_et[mem_car_sel] <= mem_entry_time_in;
    if (mem_write_cost) mem_cost[mem_car_sel] <= mem_cost_in;
  end
  assign mem_entry_time_out = mem_et[mem_car_sel];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_time(input logic [9:0] t);
    int n = 0;
    while (now_time !== t && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (now_time !== t) begin
      fails++;
      $display("FAIL wait_time: now_time=%0d expected %0d", now_time, t);
    end
  endtask

  task automatic do_entry(input logic [2:0] car, input logic [9:0] t, input logic [7:0] exp_occ);
    wait_time(t);
    entry_req = 1'b1;
    req_car   = car;
    @(negedge clk);
    entry_req = 1'b0;
    checks++; if (mem_write_entry !== 1'b1) begin fails++; $display("FAIL entry_strobe: got %b expected 1", mem_write_entry); end
    checks++; if (mem_car_sel !== car) begin fails++; $display("FAIL entry_sel: got %0d expected %0d", mem_car_sel, car); end
    checks++; if (mem_entry_time_in !== t) begin fails++; $display("FAIL entry_data: got %0d expected %0d", mem_entry_time_in, t); end
    checks++; if (req_ready !== 1'b0 || mem_write_cost !== 1'b0) begin fails++; $display("FAIL entry_busy: ready=%b cost_wr=%b expected 0 0", req_ready, mem_write_cost); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || mem_write_entry !== 1'b0) begin fails++; $display("FAIL entry_done: done=%b wr=%b expected 1 0", done, mem_write_entry); end
    checks++; if (occupied !== exp_occ) begin fails++; $display("FAIL entry_occ: got %h expected %h", occupied, exp_occ); end
    checks++; if (mem_et[car] !== t) begin fails++; $display("FAIL entry_mem: got %0d expected %0d", mem_et[car], t); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL entry_idle: done=%b ready=%b expected 0 1", done, req_ready); end
    $display("entry car %0d at t=%0d occupied=%h", car, t, occupied);
  endtask

  task automatic do_exit(input logic [2:0] car, input logic [9:0] t, input logic [9:0] exp_fee,
                         input logic [7:0] exp_occ, input logic busy_en, input logic [2:0] busy_car);
    wait_time(t);
    exit_req = 1'b1;
    req_car  = car;
    @(negedge clk);
    exit_req = 1'b0;
    if (busy_en) begin
      entry_req = 1'b1;
      req_car   = busy_car;
    end
    checks++; if (req_ready !== 1'b0 || mem_car_sel !== car) begin fails++; $display("FAIL exit_rd: ready=%b sel=%0d expected 0 %0d", req_ready, mem_car_sel, car); end
    checks++; if (mem_write_cost !== 1'b0 || mem_write_entry !== 1'b0) begin fails++; $display("FAIL exit_rd_strobe: cost=%b entry=%b expected 0 0", mem_write_cost, mem_write_entry); end
    @(negedge clk);
    checks++; if (mem_write_cost !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL exit_calc: cost_wr=%b done=%b expected 0 0", mem_write_cost, done); end
    @(negedge clk);
    entry_req = 1'b0;
    checks++; if (mem_write_cost !== 1'b1 || mem_write_entry !== 1'b0) begin fails++; $display("FAIL exit_strobe: cost=%b entry=%b expected 1 0", mem_write_cost, mem_write_entry); end
    checks++; if (mem_cost_in !== exp_fee) begin fails++; $display("FAIL exit_cost_data: got %0d expected %0d", mem_cost_in, exp_fee); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || mem_write_cost !== 1'b0) begin fails++; $display("FAIL exit_done: done=%b cost_wr=%b expected 1 0", done, mem_write_cost); end
    checks++; if (fee !== exp_fee) begin fails++; $display("FAIL exit_fee: got %0d expected %0d", fee, exp_fee); end
    checks++; if (mem_cost[car] !== exp_fee) begin fails++; $display("FAIL exit_mem_cost: got %0d expected %0d", mem_cost[car], exp_fee); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || req_ready !== 1'b1 || mem_write_entry !== 1'b0) begin fails++; $display("FAIL exit_idle: done=%b ready=%b wr=%b expected 0 1 0", done, req_ready, mem_write_entry); end
    checks++; if (occupied !== exp_occ) begin fails++; $display("FAIL exit_occ: got %h expected %h", occupied, exp_occ); end
    $display("exit car %0d at t=%0d fee=%0d occupied=%h", car, t, fee, occupied);
  endtask

  task automatic do_err(input logic en, input logic ex, input logic [2:0] car,
                        input logic [7:0] exp_occ, input logic [9:0] exp_fee);
    entry_req = en;
    exit_req  = ex;
    req_car   = car;
    @(negedge clk);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    checks++; if (err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL err_pulse: err=%b done=%b expected 1 0", err, done); end
    checks++; if (mem_write_entry !== 1'b0 || mem_write_cost !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL err_quiet: wr=%b cost=%b ready=%b expected 0 0 1", mem_write_entry, mem_write_cost, req_ready); end
    @(negedge clk);
    checks++; if (err !== 1'b0 || mem_write_entry !== 1'b0 || mem_write_cost !== 1'b0) begin fails++; $display("FAIL err_single: err=%b wr=%b cost=%b expected 0 0 0", err, mem_write_entry, mem_write_cost); end
    checks++; if (occupied !== exp_occ || fee !== exp_fee) begin fails++; $display("FAIL err_state: occ=%h fee=%0d expected %h %0d", occupied, fee, exp_occ, exp_fee); end
    $display("rejected entry=%b exit=%b car %0d", en, ex, car);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_ctrl: ready=%b done=%b err=%b expected 1 0 0", req_ready, done, err); end
    checks++; if (fee !== 10'd0 || occupied !== 8'd0 || now_time !== 10'd0) begin fails++; $display("FAIL reset_state: fee=%0d occ=%h now=%0d expected 0 0 0", fee, occupied, now_time); end
    checks++; if (mem_car_sel !== 3'd0 || mem_write_entry !== 1'b0 || mem_write_cost !== 1'b0 || mem_entry_time_in !== 10'd0 || mem_cost_in !== 10'd0) begin fails++; $display("FAIL reset_mem: sel=%0d wr=%b cost=%b et=%0d c=%0d expected all 0", mem_car_sel, mem_write_entry, mem_write_cost, mem_entry_time_in, mem_cost_in); end
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_timebase;
    repeat (3) @(negedge clk);
    checks++; if (now_time !== 10'd0) begin fails++; $display("FAIL tick_3: now=%0d expected 0", now_time); end
    @(negedge clk);
    checks++; if (now_time !== 10'd1) begin fails++; $display("FAIL tick_4: now=%0d expected 1", now_time); end
    repeat (3) @(negedge clk);
    checks++; if (now_time !== 10'd1) begin fails++; $display("FAIL tick_7: now=%0d expected 1", now_time); end
    @(negedge clk);
    checks++; if (now_time !== 10'd2) begin fails++; $display("FAIL tick_8: now=%0d expected 2", now_time); end
    $display("time base advanced to %0d after 8 cycles", now_time);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_entry_exit;
    do_entry(3'd0, 10'd0, 8'h01);
    do_entry(3'd1, 10'd5, 8'h03);
    do_exit(3'd1, 10'd17, 10'd24, 8'h01, 1'b1, 3'd6);
  endtask

  task automatic test_errors;
    do_err(1'b1, 1'b0, 3'd0, 8'h01, 10'd24);
    do_err(1'b0, 1'b1, 3'd5, 8'h01, 10'd24);
    do_err(1'b1, 1'b1, 3'd2, 8'h01, 10'd24);
  endtask

  task automatic test_saturation;
    do_exit(3'd0, 10'd600, 10'd1023, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic test_wrap;
    do_entry(3'd3, 10'd1020, 8'h08);
    do_exit(3'd3, 10'd4, 10'd16, 8'h00, 1'b0, 3'd0);
  endtask

  task automatic test_reset_mid_exit;
    int strobes = 0;
    do_entry(3'd2, 10'd10, 8'h04);
    wait_time(10'd12);
    exit_req = 1'b1;
    req_car  = 3'd2;
    @(negedge clk);
    exit_req  = 1'b0;
    entry_req = 1'b1;
    req_car   = 3'd4;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (done !== 1'b0 || err !== 1'b0 || mem_write_entry !== 1'b0 || mem_write_cost !== 1'b0) begin fails++; $display("FAIL midrst_strobes: done=%b err=%b wr=%b cost=%b expected 0", done, err, mem_write_entry, mem_write_cost); end
    checks++; if (fee !== 10'd0 || occupied !== 8'd0 || now_time !== 10'd0 || req_ready !== 1'b1) begin fails++; $display("FAIL midrst_state: fee=%0d occ=%h now=%0d ready=%b expected 0 0 0 1", fee, occupied, now_time, req_ready); end
    checks++; if (mem_car_sel !== 3'd0 || mem_entry_time_in !== 10'd0 || mem_cost_in !== 10'd0) begin fails++; $display("FAIL midrst_mem: sel=%0d et=%0d c=%0d expected 0", mem_car_sel, mem_entry_time_in, mem_cost_in); end
    entry_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_write_cost !== 1'b0 || mem_write_entry !== 1'b0) strobes++;
    end
    checks++; if (strobes !== 0) begin fails++; $display("FAIL midrst_nowrite: strobe cycles=%0d expected 0", strobes); end
    checks++; if (occupied !== 8'd0 || done !== 1'b0) begin fails++; $display("FAIL midrst_after: occ=%h done=%b expected 0 0", occupied, done); end
    $display("reset during exit of car 2 aborted the request");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_et[i]   = '0;
      mem_cost[i] = '0;
    end
    test_reset();
    test_timebase();
    test_entry_exit();
    test_errors();
    test_saturation();
    test_wrap();
    test_reset_mid_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
